// File: rtl/demux_pkg.sv
// Shared types and constants for the ADG732 channel scan sequencer.
// Holds the FSM state encoding and channel geometry.
package demux_pkg;

    localparam int CH_W   = 5;
    localparam int NUM_CH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Down-counter that measures the hold time on one channel.
// A load of 0 is treated as 1 so every channel dwells at least one cycle.
module scan_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Count register: load wins over tick, tick stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (load_val == '0) ? W'(1) : load_val;
        end else if (tick && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Last dwell cycle is the one where the count reads 1.
    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/demux_scan_seq.sv
// Channel scan sequencer feeding an ADG732 driver over a valid/ready port.
// Optional build macro SCAN_SKIP_MASK_EN adds a per-channel skip mask.
module demux_scan_seq
    import demux_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [CH_W-1:0]    first_ch,
    input  logic [CH_W-1:0]    last_ch,
    input  logic [DWELL_W-1:0] dwell_cycles,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [NUM_CH-1:0]  skip_mask,
`endif
    output logic [CH_W-1:0]    ch_out,
    output logic               ch_valid,
    input  logic               ch_ready,
    output logic               busy,
    output logic               scan_done
);

    state_t state_q, state_nxt;

    logic [CH_W-1:0]    cur_q, cur_nxt;
    logic [CH_W-1:0]    first_q, last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic               pend_q, pend_nxt;
    logic               hit_q, hit_nxt;
    logic               cap;
    logic               adv;
    logic               load;
    logic               expired;
    logic               hs;
    logic               done_nxt;
    logic               valid_nxt;
    logic               busy_nxt;
    logic               skip_nxt;

    assign hs     = ch_valid & ch_ready;
    assign ch_out = cur_q;

    scan_dwell_timer #(
        .W(DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (dwell_q),
        .tick     (state_q == DWELL),
        .expired  (expired)
    );

`ifdef SCAN_SKIP_MASK_EN
    logic [NUM_CH-1:0] mask_q, mask_nxt;

    // Mask is captured together with the rest of the scan config.
    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_nxt;
    end

    // Skip decision looks at the channel about to be presented.
    always_comb begin
        mask_nxt = cap ? skip_mask : mask_q;
        skip_nxt = mask_nxt[cur_nxt];
    end
`else
    assign skip_nxt = 1'b0;
`endif

    // State, scan config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            dwell_q   <= '0;
            cont_q    <= 1'b0;
            pend_q    <= 1'b0;
            hit_q     <= 1'b0;
            ch_valid  <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cur_q     <= cur_nxt;
            pend_q    <= pend_nxt;
            hit_q     <= hit_nxt;
            ch_valid  <= valid_nxt;
            busy      <= busy_nxt;
            scan_done <= done_nxt;
            if (cap) begin
                first_q <= first_ch;
                last_q  <= last_ch;
                dwell_q <= dwell_cycles;
                cont_q  <= continuous;
            end
        end
    end

    // Next state: handshake, dwell expiry, stop handling and channel step.
    always_comb begin
        state_nxt = state_q;
        cur_nxt   = cur_q;
        pend_nxt  = pend_q;
        hit_nxt   = hit_q;
        done_nxt  = 1'b0;
        cap       = 1'b0;
        adv       = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cap       = 1'b1;
                    cur_nxt   = first_ch;
                    hit_nxt   = 1'b0;
                    pend_nxt  = 1'b0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (ch_valid) begin
                    if (hs) begin
                        hit_nxt = 1'b1;
                        if (stop || pend_q) begin
                            pend_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            load      = 1'b1;
                            state_nxt = DWELL;
                        end
                    end else if (stop) begin
                        pend_nxt = 1'b1;
                    end
                end else if (stop || pend_q) begin
                    pend_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    adv = 1'b1;
                end
            end
            DWELL: begin
                if (stop) state_nxt = IDLE;
                else if (expired) adv = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (adv) begin
            if (cur_q != last_q) begin
                cur_nxt   = cur_q + CH_W'(1);
                state_nxt = ISSUE;
            end else if (cont_q && hit_q) begin
                cur_nxt   = first_q;
                hit_nxt   = 1'b0;
                state_nxt = ISSUE;
            end else begin
                done_nxt  = !cont_q;
                state_nxt = IDLE;
            end
        end
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        valid_nxt = (state_nxt == ISSUE) && !skip_nxt;
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_demux_scan_seq.sv
// Directed self-checking bench for demux_scan_seq.
// Mask vectors run only when SCAN_SKIP_MASK_EN is defined.
module tb_demux_scan_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [4:0]  first_ch = '0;
    logic [4:0]  last_ch = '0;
    logic [23:0] dwell_cycles = '0;
    logic [4:0]  ch_out;
    logic        ch_valid;
    logic        ch_ready = 1'b1;
    logic        busy;
    logic        scan_done;
`ifdef SCAN_SKIP_MASK_EN
    logic [31:0] skip_mask = '0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    demux_scan_seq #(.DWELL_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .first_ch     (first_ch),
        .last_ch      (last_ch),
        .dwell_cycles (dwell_cycles),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask    (skip_mask),
`endif
        .ch_out       (ch_out),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .busy         (busy),
        .scan_done    (scan_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(ch_valid), 0);
        chk({tag, "_out"}, 32'(ch_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(scan_done), 0);
    endtask

    task automatic go(input logic [4:0] f, input logic [4:0] l,
                      input logic [23:0] d, input logic c);
        first_ch = f;
        last_ch = l;
        dwell_cycles = d;
        continuous = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [0:6];
        seq = '{30, 31, 0, 1, 30, 31, 0};

        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        // 2..4, dwell 3, single pass: period of 4 cycles per channel
        go(5'd2, 5'd4, 24'd3, 1'b0);
        for (int k = 0; k < 14; k++) begin
            chk("t1_valid", 32'(ch_valid), 32'(k % 4 == 0 && k < 12));
            if (k % 4 == 0 && k < 12)
                chk("t1_ch", 32'(ch_out), 32'(2 + k / 4));
            chk("t1_done", 32'(scan_done), 32'(k == 12));
            chk("t1_busy", 32'(busy), 32'(k < 12));
            tick();
        end

        // 30..1 continuous with dwell 2: wraps through 31 -> 0
        go(5'd30, 5'd1, 24'd2, 1'b1);
        for (int k = 0; k < 19; k++) begin
            chk("t2_valid", 32'(ch_valid), 32'(k % 3 == 0));
            if (k % 3 == 0)
                chk("t2_ch", 32'(ch_out), 32'(seq[k / 3]));
            chk("t2_done", 32'(scan_done), 0);
            if (k < 18) tick();
        end
        tick();
        chk("t2_in_dwell", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_busy", 32'(busy), 0);
        chk("t2_stop_valid", 32'(ch_valid), 0);
        chk("t2_stop_done", 32'(scan_done), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_after_valid", 32'(ch_valid), 0);
            chk("t2_after_done", 32'(scan_done), 0);
        end

        // ready low for 10 cycles, stop pulse at cycle 3
        ch_ready = 1'b0;
        go(5'd5, 5'd6, 24'd1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            stop = (i == 3);
            tick();
            chk("t3_hold_valid", 32'(ch_valid), 1);
            chk("t3_hold_ch", 32'(ch_out), 5);
            chk("t3_hold_busy", 32'(busy), 1);
        end
        stop = 1'b0;
        ch_ready = 1'b1;
        tick();
        chk("t3_idle_busy", 32'(busy), 0);
        chk("t3_idle_valid", 32'(ch_valid), 0);
        chk("t3_idle_done", 32'(scan_done), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_no_issue", 32'(ch_valid), 0);
        end

        // dwell 0 acts as 1
        go(5'd7, 5'd8, 24'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("t4_valid", 32'(ch_valid), 32'(k % 2 == 0 && k < 4));
            if (k % 2 == 0 && k < 4)
                chk("t4_ch", 32'(ch_out), 32'(7 + k / 2));
            chk("t4_done", 32'(scan_done), 32'(k == 4));
            tick();
        end

        // start and stop together: stays idle
        first_ch = 5'd3;
        last_ch = 5'd3;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(ch_valid), 0);
        tick();
        chk("t5_busy2", 32'(busy), 0);

        // first == last: one channel per pass
        go(5'd9, 5'd9, 24'd1, 1'b0);
        chk("t6_valid", 32'(ch_valid), 1);
        chk("t6_ch", 32'(ch_out), 9);
        tick();
        chk("t6_dwell", 32'(ch_valid), 0);
        tick();
        chk("t6_done", 32'(scan_done), 1);
        chk("t6_busy", 32'(busy), 0);
        tick();
        chk("t6_done_pulse", 32'(scan_done), 0);

        // reset mid-DWELL
        go(5'd3, 5'd5, 24'd5, 1'b0);
        tick();
        tick();
        chk("t7_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("t7_rst_dwell");

        // reset mid-handshake in ISSUE
        ch_ready = 1'b0;
        go(5'd3, 5'd5, 24'd5, 1'b0);
        chk("t8_valid", 32'(ch_valid), 1);
        chk("t8_ch", 32'(ch_out), 3);
        rst = 1'b1;
        ch_ready = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk_idle("t8_rst_issue");
        tick();
        chk_idle("t8_after");

`ifdef SCAN_SKIP_MASK_EN
        // mask 0x0A over 0..4: issues 0, 2, 4
        skip_mask = 32'h0000_000A;
        go(5'd0, 5'd4, 24'd1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("m1_valid", 32'(ch_valid),
                32'(k == 0 || k == 3 || k == 6));
            if (k == 0 || k == 3 || k == 6)
                chk("m1_ch", 32'(ch_out), 32'(k == 0 ? 0 : (k == 3 ? 2 : 4)));
            chk("m1_done", 32'(scan_done), 32'(k == 8));
            tick();
        end

        // every channel masked: no valid, done pulse
        skip_mask = 32'hFFFF_FFFF;
        go(5'd0, 5'd4, 24'd1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            chk("m2_valid", 32'(ch_valid), 0);
            chk("m2_done", 32'(scan_done), 32'(k == 5));
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
